// File: rtl/clk_ratio_detector_pkg.sv
// Shared clock-divider definitions: measurement FSM states and default
// counter sizing for the ratio detector.
package clk_ratio_detector_pkg;

    localparam int unsigned CRD_CNT_W    = 8;
    localparam int unsigned CRD_LOCK_CNT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        TRACK = 2'd2
    } crd_state_e;

endpackage

// File: rtl/clk_ratio_detector_edge_detect.sv
// Rising-edge detector for a same-domain level input; rise is combinational
// from the current input and the registered previous sample.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic prev_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_in <= 1'b0;
        end else begin
            prev_in <= in;
        end
    end

    assign rise = in & ~prev_in;

endmodule

// File: rtl/clk_ratio_detector.sv
// Measures period and high time of a same-domain divided clock, flags lock
// after LOCK_CNT equal periods and reports a stuck input via err.
module clk_ratio_detector
    import clk_ratio_detector_pkg::*;
#(
    parameter int unsigned CNT_W    = CRD_CNT_W,
    parameter int unsigned LOCK_CNT = CRD_LOCK_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_clk_in,
    output logic [CNT_W-1:0] ratio,
    output logic [CNT_W-1:0] high_cnt,
    output logic             ratio_valid,
    output logic             locked,
    output logic             err
);

    localparam int unsigned   MATCH_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [MATCH_W-1:0] MATCH_TOP = MATCH_W'(LOCK_CNT);

    crd_state_e         state_q, state_d;
    logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]   hi_acc_q, hi_acc_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [CNT_W-1:0]   ratio_d, high_cnt_d;
    logic               ratio_valid_d, locked_d, err_d;
    logic               rise;
    logic               capture;

    edge_detect u_edge_detect (
        .clk  (clk),
        .rst  (rst),
        .in   (div_clk_in),
        .rise (rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            per_cnt_q   <= '0;
            hi_acc_q    <= '0;
            match_q     <= '0;
            ratio       <= '0;
            high_cnt    <= '0;
            ratio_valid <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_cnt_q   <= per_cnt_d;
            hi_acc_q    <= hi_acc_d;
            match_q     <= match_d;
            ratio       <= ratio_d;
            high_cnt    <= high_cnt_d;
            ratio_valid <= ratio_valid_d;
            locked      <= locked_d;
            err         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        per_cnt_d     = per_cnt_q;
        hi_acc_d      = hi_acc_q;
        match_d       = match_q;
        ratio_d       = ratio;
        high_cnt_d    = high_cnt;
        err_d         = 1'b0;
        capture       = 1'b0;

        // Period and high-time accumulators restart on every rise.
        if (rise) begin
            per_cnt_d = CNT_W'(1);
            hi_acc_d  = CNT_W'(1);
        end else begin
            if (per_cnt_q != CNT_MAX) begin
                per_cnt_d = per_cnt_q + CNT_W'(1);
            end
            if (div_clk_in && (hi_acc_q != CNT_MAX)) begin
                hi_acc_d = hi_acc_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = FIRST;
                end
            end
            FIRST, TRACK: begin
                // A rise on the saturating cycle is still a valid capture.
                if (rise) begin
                    capture = 1'b1;
                    state_d = TRACK;
                end else if (per_cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    match_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                match_d = '0;
            end
        endcase

        if (capture) begin
            ratio_d    = per_cnt_q;
            high_cnt_d = hi_acc_q + CNT_W'(div_clk_in) - CNT_W'(1);
            if (per_cnt_q == ratio) begin
                if (match_q != MATCH_TOP) begin
                    match_d = match_q + MATCH_W'(1);
                end
            end else begin
                match_d = MATCH_W'(1);
            end
        end

        ratio_valid_d = (state_d == TRACK);
        locked_d      = (match_d == MATCH_TOP);
    end

endmodule

// File: tb/tb_clk_ratio_detector.sv
// Directed bench for clk_ratio_detector: lock, ratio change, stuck input,
// mid-run reset, divide-by-2 and a rise coinciding with saturation.
module tb_clk_ratio_detector;

    logic       clk;
    logic       rst;
    logic       div_clk_in;
    logic [7:0] ratio;
    logic [7:0] high_cnt;
    logic       ratio_valid;
    logic       locked;
    logic       err;

    int n_checks;
    int n_fail;

    clk_ratio_detector #(
        .CNT_W    (8),
        .LOCK_CNT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .div_clk_in  (div_clk_in),
        .ratio       (ratio),
        .high_cnt    (high_cnt),
        .ratio_valid (ratio_valid),
        .locked      (locked),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one input sample; outputs are then observed 1ns after the edge.
    task automatic step(input logic v);
        div_clk_in = v;
        @(posedge clk);
        #1;
    endtask

    // One divided-clock period starting with its rising sample.
    task automatic period(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b1);
        for (int i = 0; i < lo; i++) step(1'b0);
    endtask

    task automatic check_all(input string tag, input logic [7:0] r, input logic [7:0] h,
                             input logic v, input logic l, input logic e);
        check({tag, ".ratio"},       32'(ratio),       32'(r));
        check({tag, ".high_cnt"},    32'(high_cnt),    32'(h));
        check({tag, ".ratio_valid"}, 32'(ratio_valid), 32'(v));
        check({tag, ".locked"},      32'(locked),      32'(l));
        check({tag, ".err"},         32'(err),         32'(e));
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        div_clk_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("reset", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

        // mod-6, high on phases 4,5: first rise only arms the FSM
        period(2, 4);
        check_all("m6_first", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        check_all("m6_cap1", 8'd6, 8'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1);
        for (int i = 0; i < 4; i++) step(1'b0);
        period(2, 4);
        period(2, 4);
        check("m6_cap3.locked", 32'(locked), 32'd0);
        period(2, 4);
        check_all("m6_lock", 8'd6, 8'd2, 1'b1, 1'b1, 1'b0);

        // hold low: last rise was 5 samples ago, err on the 255th sample after it
        for (int i = 0; i < 249; i++) step(1'b0);
        check_all("stuck_254", 8'd6, 8'd2, 1'b1, 1'b1, 1'b0);
        step(1'b0);
        check_all("stuck_err", 8'd6, 8'd2, 1'b0, 1'b0, 1'b1);
        step(1'b0);
        check("stuck_err_once", 32'(err), 32'd0);
        for (int i = 0; i < 10; i++) step(1'b0);
        check("stuck_quiet", 32'(err), 32'd0);

        // restart mod-6 from IDLE, relock
        period(2, 4);
        check_all("re6_first", 8'd6, 8'd2, 1'b0, 1'b0, 1'b0);
        period(2, 4);
        check_all("re6_cap1", 8'd6, 8'd2, 1'b1, 1'b0, 1'b0);
        period(2, 4);
        period(2, 4);
        period(2, 4);
        check("re6_lock", 32'(locked), 32'd1);

        // switch to ratio 4: first new rise still measures the old 6-period
        period(2, 2);
        check_all("sw_old6", 8'd6, 8'd2, 1'b1, 1'b1, 1'b0);
        step(1'b1);
        check_all("sw_cap4", 8'd4, 8'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        period(2, 2);
        period(2, 2);
        check("sw_cap3.locked", 32'(locked), 32'd0);
        period(2, 2);
        check_all("sw_relock", 8'd4, 8'd2, 1'b1, 1'b1, 1'b0);

        // async reset between rises while tracking
        step(1'b1);
        step(1'b1);
        step(1'b0);
        rst = 1'b1;
        #1;
        check_all("rst_async", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0);
        rst = 1'b0;
        period(2, 2);
        check_all("rst_first", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        check_all("rst_cap1", 8'd4, 8'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b0);

        // divide-by-2 toggle
        period(1, 1);
        check("d2_old4.ratio", 32'(ratio), 32'd4);
        period(1, 1);
        check_all("d2_cap1", 8'd2, 8'd1, 1'b1, 1'b0, 1'b0);
        period(1, 1);
        period(1, 1);
        check("d2_cap3.locked", 32'(locked), 32'd0);
        period(1, 1);
        check_all("d2_lock", 8'd2, 8'd1, 1'b1, 1'b1, 1'b0);

        // 255-cycle period: rise lands on the saturating cycle, capture wins
        period(1, 254);
        check_all("sat_pre", 8'd2, 8'd1, 1'b1, 1'b1, 1'b0);
        step(1'b1);
        check_all("sat_cap", 8'd255, 8'd1, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_ratio_detector.md
CLK_RATIO_DETECTOR -- requirements
Module: clk_ratio_detector

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of period and high-time counters.
REQ-002 SHALL have parameter LOCK_CNT, default 4: number of consecutive equal periods required for lock.
REQ-003 SHALL have port clk, input, 1: single reference clock; every flop in the block is clocked by it.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port div_clk_in, input, 1: divided clock generated from clk in the same clock domain; no synchronizer is used.
REQ-006 SHALL have port ratio, output, CNT_W: last measured period, in clk cycles.
REQ-007 SHALL have port high_cnt, output, CNT_W: number of clk cycles div_clk_in was high in the last measured period.
REQ-008 SHALL have port ratio_valid, output, 1: ratio and high_cnt hold a complete measurement.
REQ-009 SHALL have port locked, output, 1: the last LOCK_CNT periods were all equal.
REQ-010 SHALL have port err, output, 1: one-cycle pulse on period-counter saturation.

Function
REQ-011 SHALL register div_clk_in into prev_in each cycle; a rise is div_clk_in=1 while prev_in=0.
REQ-012 SHALL run per_cnt: loads 1 on a rise; otherwise increments by 1, saturating at 2^CNT_W-1.
REQ-013 SHALL run hi_acc: loads 1 on a rise; otherwise increments when div_clk_in=1, saturating.
REQ-014 SHALL implement a state machine with states IDLE, FIRST and TRACK.
REQ-015 SHALL move IDLE->FIRST on the first rise, with no capture.
REQ-016 SHALL, on a rise in FIRST, capture ratio<=per_cnt and high_cnt<=hi_acc+div_clk_in-1, and go to TRACK.
REQ-017 SHALL, on every rise in TRACK, capture ratio and high_cnt using the same rule as REQ-016.
REQ-018 SHALL keep the captured high_cnt equal to the number of high samples over exactly ratio cycles.
REQ-019 SHALL assert ratio_valid in TRACK; outputs update 1 cycle after the cycle in which the rise is sampled.
REQ-020 SHALL track matches with a match counter: a capture equal to the previous ratio increments it, saturating at LOCK_CNT; an unequal capture loads it with 1.
REQ-021 SHALL assert locked while the match counter equals LOCK_CNT; locked deasserts on the same cycle a mismatching capture is registered.
REQ-022 SHALL, if per_cnt reaches 2^CNT_W-1 in FIRST or TRACK (stuck input), pulse err for one cycle, go to IDLE, and clear ratio_valid, locked and the match counter.
REQ-023 SHALL leave ratio and high_cnt holding their last values after an err, until the next capture.
REQ-024 SHALL fix the minimum measurable period at 2 cycles (1 high, 1 low); a constant-high or constant-low input produces no rise.
REQ-025 SHALL treat a rise coinciding with saturation as a rise: the capture wins, and there is no err.

Reset
REQ-026 SHALL, on rst, asynchronously clear state to IDLE, and clear prev_in, per_cnt, hi_acc, match counter, ratio, high_cnt, ratio_valid, locked and err to 0.
REQ-027 SHALL, on rst asserted mid-measurement, abandon the measurement; the first capture after release occurs on the second rise.

Structure
REQ-028 SHALL place the state enum (IDLE/FIRST/TRACK) and the default CNT_W/LOCK_CNT constants in the shared clock-divider package.
REQ-029 SHALL implement rise detection as sub-module edge_detect (clk, rst, in, rise), instantiated once.

Verification
REQ-030 SHALL cover: mod-6 pattern (high cycles 4,5 of 0..5) -> ratio=6, high_cnt=2, ratio_valid after 2nd rise, locked after 4th equal capture.
REQ-031 SHALL cover: ratio switched 6->4 (50% duty) mid-run -> next capture ratio=4, high_cnt=2, locked drops same cycle, relocks after 4 captures of 4.
REQ-032 SHALL cover: input held low after lock -> err pulses once 255 cycles after last rise, ratio_valid=0, locked=0, ratio stays 6.
REQ-033 SHALL cover: rst pulsed between rises in TRACK -> all outputs 0 immediately; first valid capture on 2nd rise after release.
REQ-034 SHALL cover: div-by-2 toggle input -> ratio=2, high_cnt=1, locked after 4 captures.
